// File: rtl/coherence_pkg.sv
// Shared types and constants for the snooping coherence bus controller.
package coherence_pkg;

    // L2 request-port status as driven by the shared L2.
    typedef enum logic [1:0] {
        L2Free   = 2'd0,
        L2Busy   = 2'd1,
        L2Access = 2'd2,
        L2Error  = 2'd3
    } l2_state_t;

    localparam int unsigned WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    // Returned to the requester when the L2 reports an error.
    localparam word_t BAD_DATA = 32'hBAD1_BAD1;

    // Bus transaction state machine.
    typedef enum logic [2:0] {
        StIdle,
        StSnoop,
        StResp,
        StC2c,
        StC2cWb,
        StL2Rd,
        StL2Wr,
        StDone
    } cc_state_t;

    // Transaction kind, fixed at grant time.
    typedef enum logic [1:0] {
        TxnWb,
        TxnRd,
        TxnRdx,
        TxnUpgr
    } txn_t;

    // A coherence request outranks a writeback from the same cache.
    function automatic txn_t decode_txn(input logic trans, input logic ren, input logic wr);
        if (!trans) begin
            return TxnWb;
        end
        if (ren) begin
            return wr ? TxnRdx : TxnRd;
        end
        return wr ? TxnUpgr : TxnRd;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from pointer+1,
// pointer moves to the grantee when the update enable is high.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic            update_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] ptr_q;

    // Pick the first requester after the pointer, wrapping around.
    always_comb begin
        logic [IdxW-1:0] cand;
        cand    = '0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
        gnt_o[idx_o] = valid_o;
    end

    // Pointer starts at N-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= IdxW'(N - 1);
        end else if (update_i && valid_o) begin
            ptr_q <= idx_o;
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping MESI-style bus controller between N private L1 data caches and
// a shared L2: arbitrates requests, snoops peers, forwards dirty lines
// cache-to-cache (with L2 writeback) and reports L2 errors.
module coherence_bus_ctrl
    import coherence_pkg::*;
#(
    parameter int unsigned CPUS   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*DATA_W-1:0]   dstore,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*DATA_W-1:0]   dload,
    input  logic [CPUS-1:0]          cctrans,
    input  logic [CPUS-1:0]          ccwrite,
    input  logic [CPUS-1:0]          cchit,
    input  logic [CPUS-1:0]          ccdirty,
    output logic [CPUS-1:0]          ccwait,
    output logic [CPUS-1:0]          ccinv,
    output logic [CPUS-1:0]          ccexclusive,
    output logic [CPUS*ADDR_W-1:0]   ccsnpaddr,
    input  l2_state_t                l2state,
    input  logic [DATA_W-1:0]        l2load,
    output logic                     l2REN,
    output logic                     l2WEN,
    output logic [ADDR_W-1:0]        l2addr,
    output logic [DATA_W-1:0]        l2store,
    output logic                     l2err
);

    localparam int unsigned IdxW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [DATA_W-1:0] BadData = DATA_W'(BAD_DATA);

    cc_state_t         state_q;
    txn_t              txn_q;
    logic [CPUS-1:0]   req_oh_q;
    logic [IdxW-1:0]   owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              hit_q;
    logic [CPUS-1:0]   dwait_q;
    logic [DATA_W-1:0] dload_q;
    logic [CPUS-1:0]   ccwait_q;
    logic [CPUS-1:0]   ccinv_q;
    logic [CPUS-1:0]   ccexcl_q;
    logic              l2ren_q;
    logic              l2wen_q;
    logic [ADDR_W-1:0] l2addr_q;
    logic [DATA_W-1:0] l2store_q;
    logic              l2err_q;

    logic [ADDR_W-1:0] daddr_a  [CPUS];
    logic [DATA_W-1:0] dstore_a [CPUS];

    // Per-cache views of the flat buses; dload and ccsnpaddr only carry
    // data to the cache currently completing or being snooped.
    for (genvar i = 0; i < CPUS; i++) begin : g_lane
        assign daddr_a[i]  = daddr[i*ADDR_W +: ADDR_W];
        assign dstore_a[i] = dstore[i*DATA_W +: DATA_W];
        assign dload[i*DATA_W +: DATA_W]     = dwait_q[i] ? '0 : dload_q;
        assign ccsnpaddr[i*ADDR_W +: ADDR_W] = ccwait_q[i] ? addr_q : '0;
    end

    logic [CPUS-1:0] arb_req;
    logic [CPUS-1:0] arb_gnt;
    logic [IdxW-1:0] arb_idx;
    logic            arb_valid;
    logic            arb_update;
    txn_t            grant_txn;

    // A cache under snoop cannot raise a new request this cycle.
    assign arb_req    = (cctrans | dWEN) & ~ccwait_q;
    assign arb_update = (state_q == StIdle);
    assign grant_txn  = decode_txn(cctrans[arb_idx], dREN[arb_idx], ccwrite[arb_idx]);

    rr_arbiter #(
        .N (CPUS)
    ) u_arb (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .req_i    (arb_req),
        .update_i (arb_update),
        .gnt_o    (arb_gnt),
        .idx_o    (arb_idx),
        .valid_o  (arb_valid)
    );

    logic [CPUS-1:0] dirty_vec;
    logic [CPUS-1:0] dirty_oh;
    logic            dirty_any;
    logic [IdxW-1:0] dirty_idx;

    // Lowest-index dirty snooper becomes the cache-to-cache data owner.
    always_comb begin
        logic [IdxW-1:0] cand;
        cand      = '0;
        dirty_vec = ccdirty & ~req_oh_q;
        dirty_oh  = dirty_vec & (~dirty_vec + CPUS'(1));
        dirty_any = |dirty_vec;
        dirty_idx = '0;
        for (int unsigned i = 0; i < CPUS; i++) begin
            cand = IdxW'(CPUS - 1 - i);
            if (dirty_vec[cand]) begin
                dirty_idx = cand;
            end
        end
    end

    logic              l2_wait;
    logic              l2_err_now;
    logic              l2_fin;
    logic              excl_now;
    logic [DATA_W-1:0] fin_data;

    // Completion decode shared by every state that waits on the L2.
    always_comb begin
        l2_wait    = state_q inside {StL2Rd, StL2Wr, StC2cWb};
        l2_err_now = l2_wait && (l2state == L2Error);
        l2_fin     = l2_wait && ((l2state == L2Access) || (l2state == L2Error));
        fin_data   = l2_err_now ? BadData : ((state_q == StL2Rd) ? l2load : data_q);
        excl_now   = (txn_q == TxnRdx) || (txn_q == TxnUpgr) || ((txn_q == TxnRd) && !hit_q);
    end

    // Transaction FSM; every bus output is a register updated on transitions.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            txn_q     <= TxnWb;
            req_oh_q  <= '0;
            owner_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            hit_q     <= 1'b0;
            dwait_q   <= '1;
            dload_q   <= '0;
            ccwait_q  <= '0;
            ccinv_q   <= '0;
            ccexcl_q  <= '0;
            l2ren_q   <= 1'b0;
            l2wen_q   <= 1'b0;
            l2addr_q  <= '0;
            l2store_q <= '0;
            l2err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        req_oh_q <= arb_gnt;
                        addr_q   <= daddr_a[arb_idx];
                        data_q   <= dstore_a[arb_idx];
                        txn_q    <= grant_txn;
                        hit_q    <= 1'b0;
                        if (grant_txn == TxnWb) begin
                            l2wen_q   <= 1'b1;
                            l2addr_q  <= daddr_a[arb_idx];
                            l2store_q <= dstore_a[arb_idx];
                            state_q   <= StL2Wr;
                        end else begin
                            ccwait_q <= ~arb_gnt;
                            ccinv_q  <= ccwrite[arb_idx] ? ~arb_gnt : '0;
                            state_q  <= StSnoop;
                        end
                    end
                end
                StSnoop: begin
                    state_q <= StResp;
                end
                StResp: begin
                    hit_q <= |(cchit & ~req_oh_q);
                    if (dirty_any) begin
                        owner_q  <= dirty_idx;
                        ccwait_q <= dirty_oh;
                        ccinv_q  <= ccinv_q & dirty_oh;
                        state_q  <= StC2c;
                    end else begin
                        ccwait_q <= '0;
                        ccinv_q  <= '0;
                        if (txn_q == TxnUpgr) begin
                            // Peers are already invalidated; no data moves.
                            dwait_q  <= ~req_oh_q;
                            dload_q  <= data_q;
                            ccexcl_q <= req_oh_q;
                            state_q  <= StDone;
                        end else begin
                            l2ren_q  <= 1'b1;
                            l2addr_q <= addr_q;
                            state_q  <= StL2Rd;
                        end
                    end
                end
                StC2c: begin
                    // Owner's line goes to L2 first; requester gets it on ACCESS.
                    if (dWEN[owner_q]) begin
                        data_q    <= dstore_a[owner_q];
                        l2wen_q   <= 1'b1;
                        l2addr_q  <= addr_q;
                        l2store_q <= dstore_a[owner_q];
                        ccwait_q  <= '0;
                        ccinv_q   <= '0;
                        state_q   <= StC2cWb;
                    end
                end
                StL2Rd, StL2Wr, StC2cWb: begin
                    if (l2_fin) begin
                        l2ren_q   <= 1'b0;
                        l2wen_q   <= 1'b0;
                        l2addr_q  <= '0;
                        l2store_q <= '0;
                        dload_q   <= fin_data;
                        dwait_q   <= ~req_oh_q;
                        ccexcl_q  <= excl_now ? req_oh_q : '0;
                        if (l2_err_now) begin
                            l2err_q <= 1'b1;
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    dwait_q  <= '1;
                    dload_q  <= '0;
                    ccexcl_q <= '0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dwait       = dwait_q;
    assign ccwait      = ccwait_q;
    assign ccinv       = ccinv_q;
    assign ccexclusive = ccexcl_q;
    assign l2REN       = l2ren_q;
    assign l2WEN       = l2wen_q;
    assign l2addr      = l2addr_q;
    assign l2store     = l2store_q;
    assign l2err       = l2err_q;

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl with 4 CPUs.
module tb_coherence_bus_ctrl;
    import coherence_pkg::*;

    localparam int CPUS = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                 CLK  = 1'b0;
    logic                 nRST = 1'b1;
    logic [CPUS-1:0]      dREN, dWEN, cctrans, ccwrite, cchit, ccdirty;
    logic [CPUS*AW-1:0]   daddr;
    logic [CPUS*DW-1:0]   dstore;
    logic [CPUS-1:0]      dwait, ccwait, ccinv, ccexclusive;
    logic [CPUS*DW-1:0]   dload;
    logic [CPUS*AW-1:0]   ccsnpaddr;
    l2_state_t            l2state;
    logic [DW-1:0]        l2load;
    logic                 l2REN, l2WEN, l2err;
    logic [AW-1:0]        l2addr;
    logic [DW-1:0]        l2store;

    int total = 0;
    int bad   = 0;

    coherence_bus_ctrl #(
        .CPUS   (CPUS),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .dwait       (dwait),
        .dload       (dload),
        .cctrans     (cctrans),
        .ccwrite     (ccwrite),
        .cchit       (cchit),
        .ccdirty     (ccdirty),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccexclusive (ccexclusive),
        .ccsnpaddr   (ccsnpaddr),
        .l2state     (l2state),
        .l2load      (l2load),
        .l2REN       (l2REN),
        .l2WEN       (l2WEN),
        .l2addr      (l2addr),
        .l2store     (l2store),
        .l2err       (l2err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; cchit = '0; ccdirty = '0;
        daddr = '0; dstore = '0; l2state = L2Free; l2load = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 nRST = 1'b0;
        tick();
        total++;
        if (dwait !== 4'hF) begin
            bad++; $display("FAIL reset_dwait got=%h want=%h", dwait, 4'hF);
        end
        total++;
        if ({ccwait, ccinv, ccexclusive} !== 12'h000) begin
            bad++; $display("FAIL reset_cc got=%h want=%h", {ccwait, ccinv, ccexclusive}, 12'h0);
        end
        total++;
        if (dload !== '0 || ccsnpaddr !== '0) begin
            bad++; $display("FAIL reset_buses got=%h/%h want=0", dload, ccsnpaddr);
        end
        total++;
        if ({l2REN, l2WEN, l2err} !== 3'b000 || l2addr !== '0 || l2store !== '0) begin
            bad++; $display("FAIL reset_l2 got=%b%b%b %h %h want=000 0 0",
                            l2REN, l2WEN, l2err, l2addr, l2store);
        end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_bus_rd();
        int lat;
        lat = 0;
        dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[31:0] = 32'h100;
        l2state = L2Access; l2load = 32'hDEADBEEF;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            tick();
            if (k == 1) begin
                total++;
                if (ccwait !== 4'b1110 || ccsnpaddr[63:32] !== 32'h100 || ccsnpaddr[31:0] !== 32'h0)
                begin
                    bad++; $display("FAIL rd_snoop got=%b %h want=1110 100", ccwait, ccsnpaddr);
                end
            end
            if (k == 3) begin
                total++;
                if (l2REN !== 1'b1 || l2addr !== 32'h100) begin
                    bad++; $display("FAIL rd_l2req got=%b %h want=1 100", l2REN, l2addr);
                end
            end
            if (dwait[0] === 1'b0) begin
                lat = k;
                total++;
                if (dload[31:0] !== 32'hDEADBEEF || dload[127:32] !== '0) begin
                    bad++; $display("FAIL rd_dload got=%h want=DEADBEEF in lane 0", dload);
                end
                total++;
                if (ccexclusive !== 4'b0001 || dwait !== 4'b1110) begin
                    bad++; $display("FAIL rd_done got=%b %b want=0001 1110", ccexclusive, dwait);
                end
            end
        end
        total++;
        if (lat != 4) begin
            bad++; $display("FAIL rd_latency got=%0d want=4", lat);
        end
        clear_inputs();
        tick();
        total++;
        if (dwait !== 4'hF || ccexclusive !== 4'h0) begin
            bad++; $display("FAIL rd_after got=%b %b want=1111 0000", dwait, ccexclusive);
        end
    endtask

    task automatic test_bus_rdx_c2c();
        dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[63:32] = 32'h200;
        cchit[3] = 1'b1; ccdirty[3] = 1'b1; l2state = L2Busy;
        tick();
        total++;
        if (ccwait !== 4'b1101 || ccinv !== 4'b1101 || ccsnpaddr[127:96] !== 32'h200) begin
            bad++; $display("FAIL rdx_snoop got=%b %b %h want=1101 1101 200",
                            ccwait, ccinv, ccsnpaddr[127:96]);
        end
        tick();
        tick();
        total++;
        if (ccwait !== 4'b1000 || ccinv !== 4'b1000 || l2WEN !== 1'b0) begin
            bad++; $display("FAIL rdx_c2c_hold got=%b %b %b want=1000 1000 0", ccwait, ccinv, l2WEN);
        end
        dWEN[3] = 1'b1; dstore[127:96] = 32'h12345678;
        tick();
        total++;
        if (l2WEN !== 1'b1 || l2store !== 32'h12345678 || l2addr !== 32'h200 || ccwait !== 4'h0)
        begin
            bad++; $display("FAIL rdx_wb got=%b %h %h %b want=1 12345678 200 0000",
                            l2WEN, l2store, l2addr, ccwait);
        end
        dWEN[3] = 1'b0; cchit = '0; ccdirty = '0; l2state = L2Access;
        tick();
        total++;
        if (dwait !== 4'b1101 || dload[63:32] !== 32'h12345678) begin
            bad++; $display("FAIL rdx_data got=%b %h want=1101 12345678", dwait, dload[63:32]);
        end
        total++;
        if (ccexclusive !== 4'b0010) begin
            bad++; $display("FAIL rdx_excl got=%b want=0010", ccexclusive);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_bus_upgr();
        int lat;
        logic seen_l2;
        lat = 0; seen_l2 = 1'b0;
        cctrans[2] = 1'b1; ccwrite[2] = 1'b1; daddr[95:64] = 32'h300; cchit = 4'b0011;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            tick();
            seen_l2 = seen_l2 | l2REN | l2WEN;
            if (k == 1) begin
                total++;
                if (ccinv !== 4'b1011 || ccwait !== 4'b1011) begin
                    bad++; $display("FAIL upgr_inv got=%b %b want=1011 1011", ccinv, ccwait);
                end
            end
            if (dwait[2] === 1'b0) begin
                lat = k;
                total++;
                if (ccexclusive !== 4'b0100) begin
                    bad++; $display("FAIL upgr_excl got=%b want=0100", ccexclusive);
                end
            end
        end
        total++;
        if (lat != 3) begin
            bad++; $display("FAIL upgr_latency got=%0d want=3", lat);
        end
        total++;
        if (seen_l2 !== 1'b0) begin
            bad++; $display("FAIL upgr_no_l2 got=%b want=0", seen_l2);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        int order [5];
        int exp_order [5];
        int n;
        exp_order = '{0, 1, 2, 3, 0};
        order = '{-1, -1, -1, -1, -1};
        n = 0;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        dREN = 4'hF; cctrans = 4'hF;
        daddr = {32'h1300, 32'h1200, 32'h1100, 32'h1000};
        l2state = L2Access; l2load = 32'hC0FFEE00;
        for (int k = 0; k < 60 && n < 5; k++) begin
            tick();
            for (int c = 0; c < CPUS; c++) begin
                if (dwait[c] === 1'b0 && n < 5) begin
                    order[n] = c;
                    n++;
                    total++;
                    if (dload[c*DW +: DW] !== 32'hC0FFEE00) begin
                        bad++; $display("FAIL rr_data cpu%0d got=%h want=C0FFEE00",
                                        c, dload[c*DW +: DW]);
                    end
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (order[i] != exp_order[i]) begin
                bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, order[i], exp_order[i]);
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_wb_error();
        int lat;
        int wen_cycles;
        lat = 0; wen_cycles = 0;
        dWEN[0] = 1'b1; dstore[31:0] = 32'h55AA55AA; daddr[31:0] = 32'h400; l2state = L2Busy;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (l2WEN === 1'b1) begin
                wen_cycles++;
                if (k == 1) begin
                    total++;
                    if (l2addr !== 32'h400 || l2store !== 32'h55AA55AA || l2REN !== 1'b0) begin
                        bad++; $display("FAIL wb_req got=%h %h %b want=400 55AA55AA 0",
                                        l2addr, l2store, l2REN);
                    end
                end
            end
            if (k == 5) l2state = L2Error;
            if (dwait[0] === 1'b0) begin
                lat = k;
                total++;
                if (dload[31:0] !== 32'hBAD1BAD1 || l2err !== 1'b1) begin
                    bad++; $display("FAIL wb_err got=%h %b want=BAD1BAD1 1", dload[31:0], l2err);
                end
            end
        end
        total++;
        if (wen_cycles != 5 || lat != 6) begin
            bad++; $display("FAIL wb_timing got=%0d/%0d want=5/6", wen_cycles, lat);
        end
        clear_inputs();
        tick();
        total++;
        if (l2err !== 1'b1 || dwait !== 4'hF) begin
            bad++; $display("FAIL wb_sticky got=%b %b want=1 1111", l2err, dwait);
        end
    endtask

    task automatic test_reset_in_c2c();
        dREN[1] = 1'b1; cctrans[1] = 1'b1; daddr[63:32] = 32'h600;
        cchit[2] = 1'b1; ccdirty[2] = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (ccwait !== 4'b0100) begin
            bad++; $display("FAIL c2c_reach got=%b want=0100", ccwait);
        end
        #2 nRST = 1'b0;
        #1;
        total++;
        if (dwait !== 4'hF || ccwait !== 4'h0 || ccinv !== 4'h0 || ccexclusive !== 4'h0
            || l2err !== 1'b0 || l2WEN !== 1'b0) begin
            bad++; $display("FAIL async_rst got=%b %b %b %b %b %b want=1111 0 0 0 0 0",
                            dwait, ccwait, ccinv, ccexclusive, l2err, l2WEN);
        end
        cchit = '0; ccdirty = '0;
        dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[31:0] = 32'h700;
        tick();
        total++;
        if (dwait !== 4'hF || ccwait !== 4'h0) begin
            bad++; $display("FAIL rst_hold got=%b %b want=1111 0000", dwait, ccwait);
        end
        nRST = 1'b1;
        tick();
        total++;
        if (ccwait !== 4'b1110 || ccsnpaddr[63:32] !== 32'h700) begin
            bad++; $display("FAIL rst_regrant got=%b %h want=1110 700", ccwait, ccsnpaddr[63:32]);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_bus_rd();
        test_bus_rdx_c2c();
        test_bus_upgr();
        test_round_robin();
        test_wb_error();
        test_reset_in_c2c();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Snooping coherence bus controller between CPUS private L1 data caches and one shared L2 (MESI-style: exclusive grant, invalidate, dirty cache-to-cache forwarding).
- Parametrised successor of the fixed 2-CPU coherence control interface; generalises to N CPUs.
- Adds round-robin arbitration, an explicit transaction state machine, L2 handshake, upgrade transactions and error reporting.
- Sits between the L1 coherence ports and the L2 request port.

Parameters:
- CPUS, 4, number of L1 caches (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data word width (one word per block).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- dREN  in  CPUS  per-cache read request
- dWEN  in  CPUS  per-cache write (writeback, or snoop data supply)
- daddr  in  CPUS*ADDR_W  per-cache request address
- dstore  in  CPUS*DATA_W  per-cache write/supply data
- dwait  out  CPUS  low for exactly one cycle on completion
- dload  out  CPUS*DATA_W  read data to requester
- cctrans  in  CPUS  coherence transaction request
- ccwrite  in  CPUS  requester intends to write (BusRdX/BusUpgr)
- cchit  in  CPUS  snoop hit response
- ccdirty  in  CPUS  snoop hit on modified line
- ccwait  out  CPUS  cache is being snooped
- ccinv  out  CPUS  snooped cache must invalidate
- ccexclusive  out  CPUS  requester may install line E/M
- ccsnpaddr  out  CPUS*ADDR_W  snoop address
- l2state  in  2  l2_state_t: FREE/BUSY/ACCESS/ERROR
- l2load  in  DATA_W  L2 read data, valid when ACCESS
- l2REN  out  1  L2 read
- l2WEN  out  1  L2 write
- l2addr  out  ADDR_W  L2 address
- l2store  out  DATA_W  L2 write data
- l2err  out  1  sticky, set on any L2_ERROR

Behaviour:
- Reset values: dwait all 1; everything else 0; arbiter pointer = CPUS-1 (CPU0 wins first). Async reset mid-transaction aborts to IDLE with no completion pulse.
- Transaction types, decoded at grant:
  - WB: dWEN & !cctrans.
  - BusRd: cctrans & dREN & !ccwrite.
  - BusRdX: cctrans & dREN & ccwrite.
  - BusUpgr: cctrans & ccwrite & !dREN.
- Requests are held until that cache's dwait pulse.
- IDLE: request vector = cctrans | dWEN, masking any cache with ccwait high. Round-robin grant, search starting at pointer+1. Latch req index, address, type, data. Pointer <= grantee. WB -> L2WR; others -> SNOOP. No request -> stay IDLE.
- SNOOP (1 cycle): for every j != req: ccwait[j]=1, ccsnpaddr[j]=addr, ccinv[j]=latched ccwrite. Go to RESP.
- RESP (1 cycle): ccwait is held and cchit/ccdirty sampled.
  - Any ccdirty (priority: lowest index) -> C2C.
  - Else BusUpgr -> DONE.
  - Else -> L2RD.
- C2C: ccwait held on the dirty owner only. Wait for owner dWEN. Capture its dstore, drive l2WEN with that data (writeback), then forward data to requester -> DONE once l2state==ACCESS.
- L2RD: l2REN=1 and l2addr held until l2state==ACCESS; capture l2load -> DONE.
- L2WR: l2WEN=1 with latched data until ACCESS -> DONE.
- L2_ERROR in any L2 wait state: set l2err, dload=32'hBAD1BAD1, -> DONE.
- DONE (1 cycle):
  - dwait[req]=0; dload[req] valid; ccwait/ccinv deasserted.
  - ccexclusive[req]=1 for BusRdX/BusUpgr, or BusRd with no cchit.
  - Next state IDLE. New grant no earlier than the following cycle.
- Latency:
  - BusRd/BusRdX with L2 ACCESS on the first cycle: 4 cycles, grant to dwait pulse.
  - BusUpgr: 3 cycles.
  - WB: 2 cycles plus L2 stall cycles.
- dload for non-requesters is 0. ccsnpaddr is driven only while ccwait is high, else 0.
- Simultaneous WB and coherence request from the same cache: the coherence request wins (decode priority).

Decomposition:
- coherence_pkg holds l2_state_t, word_t, the cc_state_t FSM enum, the txn_t enum (WB/RD/RDX/UPGR) and the BAD_DATA constant.
- One sub-module: rr_arbiter #(N), combinational one-hot grant plus registered pointer with an update enable.

Test Plan:
- CPU0 BusRd addr 0x100, no snoop hits, L2 ACCESS immediately with l2load 0xDEADBEEF -> dload[0]=0xDEADBEEF, ccexclusive[0]=1, dwait[0] low at cycle 4.
- CPU1 BusRdX 0x200, CPU3 cchit & ccdirty and supplies 0x12345678 -> ccinv[3]=1, l2WEN with 0x12345678, dload[1]=0x12345678, ccexclusive[1]=1.
- CPU2 BusUpgr 0x300 with CPU0 and CPU1 hitting clean -> ccinv[0,1,3]=1, no l2REN/l2WEN, dwait[2] pulse at cycle 3.
- All 4 CPUs request continuously -> grant order 0,1,2,3,0; no CPU starves.
- CPU0 WB 0x400 while L2 BUSY for 5 cycles then ERROR -> l2WEN held 5 cycles, l2err=1, dload[0]=0xBAD1BAD1.
- nRST asserted in C2C -> all outputs return to reset values asynchronously; next grant goes to CPU0.
